// File: rtl/dmem_bridge_if.sv
// Core-side request/response and SRAM-side bus of the data-memory bridge.
// The slave modport is the bridge; the master modport is the core plus SRAM environment.
interface dmem_bridge_if #(
    parameter int ADDR_WIDTH = 10
);
    // core side
    logic                  req;
    logic                  we_re;
    logic [3:0]            mask;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic                  valid;
    logic [31:0]           rdata;
    logic                  err;
    // SRAM side
    logic                  mem_cs;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  req, we_re, mask, addr, wdata, mem_rdata, mem_ready,
        output valid, rdata, err, mem_cs, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req, we_re, mask, addr, wdata, mem_rdata, mem_ready,
        input  valid, rdata, err, mem_cs, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: one outstanding load/store from the core to a wait-stated,
// byte-enabled SRAM, with window range check and a ready timeout.
module dmem_bridge #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic         clk,
    input  logic         rst,
    dmem_bridge_if.slave bus
);
    localparam int TAG_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    typedef struct packed {
        logic                  cs;
        logic                  we;
        logic [3:0]            be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
    } mem_req_t;

    state_t      state, state_d;
    mem_req_t    mreq, mreq_d;
    logic [7:0]  cnt, cnt_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        in_range;
    logic        unused_addr_lsb;

    assign in_range        = (bus.addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    // Byte lanes come only from mask; the low address bits carry no information here.
    assign unused_addr_lsb = ^bus.addr[1:0];

    always_comb begin
        state_d = state;
        mreq_d  = mreq;
        cnt_d   = cnt;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (!in_range) begin
                        state_d = ERR;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (bus.we_re && bus.mask == 4'b0000) begin
                        // empty store: nothing to write, complete without an SRAM cycle
                        state_d = DONE;
                        valid_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d      = ACCESS;
                        mreq_d.cs    = 1'b1;
                        mreq_d.we    = bus.we_re;
                        mreq_d.be    = bus.we_re ? bus.mask : 4'b1111;
                        mreq_d.addr  = bus.addr[TAG_LSB-1:2];
                        mreq_d.wdata = bus.wdata;
                        cnt_d        = '0;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt + 8'd1;
                // ready is checked first so a late ready on the timeout edge still completes
                if (bus.mem_ready) begin
                    state_d   = DONE;
                    valid_d   = 1'b1;
                    rdata_d   = mreq.we ? '0 : bus.mem_rdata;
                    mreq_d.cs = 1'b0;
                    mreq_d.we = 1'b0;
                    mreq_d.be = '0;
                end else if (cnt == TIMEOUT) begin
                    state_d   = ERR;
                    valid_d   = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    mreq_d.cs = 1'b0;
                    mreq_d.we = 1'b0;
                    mreq_d.be = '0;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mreq    <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_d;
            mreq    <= mreq_d;
            cnt     <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.valid     = valid_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_cs    = mreq.cs;
    assign bus.mem_we    = mreq.we;
    assign bus.mem_be    = mreq.be;
    assign bus.mem_addr  = mreq.addr;
    assign bus.mem_wdata = mreq.wdata;
endmodule
